// File: rtl/pong_match_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pong_match_ctrl : two-player Pong match sequencer (serve/play/point/over)
// Revision 1.0
// ---------------------------------------------------------------------------
module pong_match_ctrl #(
  parameter int WIN_SCORE    = 7,
  parameter int PAUSE_FRAMES = 120,
  parameter int OVER_FRAMES  = 180,
  parameter int SPEED_STEP   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [1:0] btn_p1,
  input  logic [1:0] btn_p2,
  input  logic       hit,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       gra_still,
  output logic       serve_dir,
  output logic [1:0] speed_lvl,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic [7:0] rally,
  output logic [2:0] state,
  output logic       winner
);

  localparam int TMAX = (PAUSE_FRAMES > OVER_FRAMES) ? PAUSE_FRAMES : OVER_FRAMES;
  localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SERVE = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_POINT = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  logic [2:0]    next_state;
  logic          btn_q;
  logic          btn_now;
  logic          press;
  logic [TW-1:0] timer;
  logic          timer_up;

  logic [TW-1:0] timer_d;
  logic [3:0]    score_p1_d, score_p2_d;
  logic [3:0]    p1_inc, p2_inc;
  logic [7:0]    rally_d, rally_inc;
  logic [1:0]    speed_d;
  logic          serve_d;
  logic          winner_d;

  assign btn_now   = (|btn_p1) | (|btn_p2);
  assign press     = btn_now & ~btn_q;
  assign timer_up  = (timer == '0);
  assign p1_inc    = score_p1 + 4'd1;
  assign p2_inc    = score_p2 + 4'd1;
  assign rally_inc = rally + 8'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Only one PLAY event per cycle: miss_left beats miss_right beats hit.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (press) next_state = S_SERVE;
      S_SERVE: if (press) next_state = S_PLAY;
      S_PLAY: begin
        if (miss_left) begin
          next_state = (p2_inc == 4'(WIN_SCORE)) ? S_OVER : S_POINT;
        end else if (miss_right) begin
          next_state = (p1_inc == 4'(WIN_SCORE)) ? S_OVER : S_POINT;
        end
      end
      S_POINT: if (timer_up) next_state = S_SERVE;
      S_OVER:  if (timer_up) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    timer_d    = (frame_tick && !timer_up) ? timer - TW'(1) : timer;
    score_p1_d = score_p1;
    score_p2_d = score_p2;
    rally_d    = rally;
    speed_d    = speed_lvl;
    serve_d    = serve_dir;
    winner_d   = winner;
    case (state)
      S_IDLE: begin
        if (press) serve_d = 1'b0;
      end
      S_SERVE: begin
        if (press) begin
          rally_d = 8'd0;
          speed_d = 2'd0;
        end
      end
      S_PLAY: begin
        if (miss_left) begin
          score_p2_d = p2_inc;
          serve_d    = 1'b0;
          if (p2_inc == 4'(WIN_SCORE)) begin
            winner_d = 1'b1;
            timer_d  = TW'(OVER_FRAMES);
          end else begin
            timer_d  = TW'(PAUSE_FRAMES);
          end
        end else if (miss_right) begin
          score_p1_d = p1_inc;
          serve_d    = 1'b1;
          if (p1_inc == 4'(WIN_SCORE)) begin
            winner_d = 1'b0;
            timer_d  = TW'(OVER_FRAMES);
          end else begin
            timer_d  = TW'(PAUSE_FRAMES);
          end
        end else if (hit && rally != 8'hFF) begin
          rally_d = rally_inc;
          if ((32'(rally_inc) % 32'(SPEED_STEP)) == 32'd0 && speed_lvl != 2'd3) begin
            speed_d = speed_lvl + 2'd1;
          end
        end
      end
      S_OVER: begin
        if (timer_up) begin
          score_p1_d = 4'd0;
          score_p2_d = 4'd0;
          rally_d    = 8'd0;
          speed_d    = 2'd0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_q     <= 1'b0;
      timer     <= '0;
      gra_still <= 1'b1;
      serve_dir <= 1'b0;
      speed_lvl <= 2'd0;
      score_p1  <= 4'd0;
      score_p2  <= 4'd0;
      rally     <= 8'd0;
      winner    <= 1'b0;
    end else begin
      btn_q     <= btn_now;
      timer     <= timer_d;
      gra_still <= (next_state != S_PLAY);
      serve_dir <= serve_d;
      speed_lvl <= speed_d;
      score_p1  <= score_p1_d;
      score_p2  <= score_p2_d;
      rally     <= rally_d;
      winner    <= winner_d;
    end
  end

endmodule
`default_nettype wire
